// File: rtl/vga_timing_monitor.sv
// VGA timing monitor for the TinyVGA Pmod bus. It recovers line and frame
// timing from the sync pulses and checks every period and pulse width. It
// declares lock after one clean frame, counts frames, and produces a 16-bit
// checksum of the active-region pixels in each frame.
//
// state   | meaning
// --------+-------------------------------------------------------------
// SEARCH  | waiting for a vsync edge; timing errors are ignored
// MEASURE | first frame after the edge is being checked
// LOCKED  | timing verified; a sum is reported on every frame boundary
module vga_timing_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_TOTAL  = 525,
  parameter bit SYNC_NEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  input  logic        clear,
  output logic        locked,
  output logic        err_hperiod,
  output logic        err_hsync,
  output logic        err_vperiod,
  output logic        err_vsync,
  output logic [15:0] frame_count,
  output logic [15:0] frame_sum,
  output logic        sum_valid
);

  localparam logic [12:0] H_TOTAL_C = 13'(H_TOTAL);
  localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
  localparam logic [11:0] H_ACT_LO  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_HI  = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [9:0]  V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0]  V_ACT_LO  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_ACT_HI  = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] H_MAX     = 12'hFFF;
  localparam logic [9:0]  V_MAX     = 10'h3FF;
  // Idle bus value: both syncs deasserted, so reset cannot fake a sync edge.
  localparam logic [7:0]  VGA_IDLE  = {SYNC_NEG, 3'b000, SYNC_NEG, 3'b000};

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [7:0]  vin_q;
  logic        hs_prev, vs_prev;
  logic        hs_now, vs_now, hs_edge, vs_edge, hs_fall, vs_fall;
  logic [11:0] hcnt, hcnt_q, hwid, hwid_q;
  logic [9:0]  vcnt, vcnt_q, vwid, vwid_q;
  logic        skip_h;
  logic [15:0] acc, acc_q;
  logic [5:0]  pixel;
  logic        active, checking;
  logic        bad_hper, bad_hsync, bad_vper, bad_vsync, err_any;
  logic        frame_done;

  assign hs_now  = vin_q[7] ^ SYNC_NEG;
  assign vs_now  = vin_q[3] ^ SYNC_NEG;
  assign hs_edge = hs_now & ~hs_prev;
  assign vs_edge = vs_now & ~vs_prev;
  assign hs_fall = ~hs_now & hs_prev;
  assign vs_fall = ~vs_now & vs_prev;
  assign pixel   = {vin_q[0], vin_q[4], vin_q[1], vin_q[5], vin_q[2], vin_q[6]};

  // Register the bus once and keep last cycle's normalised syncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vin_q   <= VGA_IDLE;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vin_q   <= vga_in;
      hs_prev <= hs_now;
      vs_prev <= vs_now;
    end
  end

  // Position and width counters as seen in the current cycle (edge cycle = 0 / 1).
  always_comb begin
    hcnt = (hcnt_q == H_MAX) ? hcnt_q : hcnt_q + 12'd1;
    if (hs_edge || (vs_edge && state_q == SEARCH)) hcnt = '0;
    hwid = hwid_q;
    if (hs_edge) hwid = 12'd1;
    else if (hs_now && hwid_q != H_MAX) hwid = hwid_q + 12'd1;
    vcnt = vcnt_q;
    if (vs_edge) vcnt = '0;
    else if (hs_edge && vcnt_q != V_MAX) vcnt = vcnt_q + 10'd1;
    vwid = vwid_q;
    if (vs_edge) vwid = 10'd1;
    else if (vs_now && hs_edge && vwid_q != V_MAX) vwid = vwid_q + 10'd1;
    active = (hcnt >= H_ACT_LO) && (hcnt < H_ACT_HI) &&
             (vcnt >= V_ACT_LO) && (vcnt < V_ACT_HI);
    acc = acc_q;
    if (vs_edge) acc = '0;
    else if (active) acc = acc_q + {10'd0, pixel};
  end

  // Checks compare the previous cycle's count, i.e. the full length just ended.
  always_comb begin
    checking  = (state_q != SEARCH);
    bad_hper  = checking && hs_edge && !skip_h && (({1'b0, hcnt_q} + 13'd1) != H_TOTAL_C);
    bad_hsync = checking && hs_fall && (hwid_q != H_SYNC_C);
    bad_vper  = checking && vs_edge && (({1'b0, vcnt_q} + 11'd1) != V_TOTAL_C);
    bad_vsync = checking && vs_fall && (vwid_q != V_SYNC_C);
    err_any   = bad_hper | bad_hsync | bad_vper | bad_vsync;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEARCH;
    else        state_q <= state_d;
  end

  // FSM next-state: an error always wins over a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (vs_edge) state_d = MEASURE;
      MEASURE: if (err_any) state_d = SEARCH;
               else if (vs_edge) state_d = LOCKED;
      LOCKED:  if (err_any) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // FSM outputs.
  always_comb begin
    locked     = (state_q == LOCKED);
    frame_done = vs_edge && !err_any && (state_q != SEARCH);
  end

  // Counters, accumulator, frame reporting and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      hwid_q      <= '0;
      vcnt_q      <= '0;
      vwid_q      <= '0;
      acc_q       <= '0;
      skip_h      <= 1'b1;
      sum_valid   <= 1'b0;
      frame_sum   <= '0;
      frame_count <= '0;
      err_hperiod <= 1'b0;
      err_hsync   <= 1'b0;
      err_vperiod <= 1'b0;
      err_vsync   <= 1'b0;
    end else begin
      hcnt_q    <= hcnt;
      hwid_q    <= hwid;
      vcnt_q    <= vcnt;
      vwid_q    <= vwid;
      acc_q     <= acc;
      // The first line seen after SEARCH may be partial, so its period is not judged.
      if (state_q == SEARCH) skip_h <= 1'b1;
      else if (hs_edge)      skip_h <= 1'b0;
      sum_valid <= frame_done;
      if (frame_done) frame_sum <= acc_q;
      if (clear)           frame_count <= '0;
      else if (frame_done) frame_count <= frame_count + 16'd1;
      err_hperiod <= bad_hper  | (err_hperiod & ~clear);
      err_hsync   <= bad_hsync | (err_hsync   & ~clear);
      err_vperiod <= bad_vper  | (err_vperiod & ~clear);
      err_vsync   <= bad_vsync | (err_vsync   & ~clear);
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor: a scaled-down timing (26x12 frame) drives two
// monitors, one expecting negative and one positive sync polarity. A
// frame-level reference model predicts which frames report a checksum and
// which error flags stick.
module tb_vga_timing_monitor;
  localparam int HA = 16, HS = 4, HB = 3, HT = 26;
  localparam int VA = 6,  VS = 2, VB = 2, VT = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [7:0]  vga_neg;
  logic [7:0]  vga_pos;
  logic [1:0]  locked_v, ehp_v, ehs_v, evp_v, evs_v, sv_v;
  logic [15:0] fc_v [2];
  logic [15:0] fs_v [2];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [15:0] exp_count;
  logic [3:0]  exp_err;      // {hperiod, hsync, vperiod, vsync}
  logic        exp_locked;
  bit          armed;
  int          rst_left;

  always #5 clk = ~clk;

  assign vga_pos = vga_neg ^ 8'h88;

  vga_timing_monitor #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
                       .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
                       .SYNC_NEG(1'b1)) u_neg (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_neg), .clear(clear),
    .locked(locked_v[0]), .err_hperiod(ehp_v[0]), .err_hsync(ehs_v[0]),
    .err_vperiod(evp_v[0]), .err_vsync(evs_v[0]), .frame_count(fc_v[0]),
    .frame_sum(fs_v[0]), .sum_valid(sv_v[0]));

  vga_timing_monitor #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
                       .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
                       .SYNC_NEG(1'b0)) u_pos (
    .clk(clk), .rst_n(rst_n), .vga_in(vga_pos), .clear(clear),
    .locked(locked_v[1]), .err_hperiod(ehp_v[1]), .err_hsync(ehs_v[1]),
    .err_vperiod(evp_v[1]), .err_vsync(evs_v[1]), .frame_count(fc_v[1]),
    .frame_sum(fs_v[1]), .sum_valid(sv_v[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one pixel clock of the negative-polarity bus.
  task automatic drive(input logic hs, input logic vs, input logic [5:0] p);
    @(negedge clk);
    vga_neg = {~hs, p[0], p[2], p[4], ~vs, p[1], p[3], p[5]};
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_locked[%0d]", tag, i), 32'(locked_v[i]), 32'd0);
      check($sformatf("%s_errs[%0d]", tag, i),
            32'({ehp_v[i], ehs_v[i], evp_v[i], evs_v[i]}), 32'd0);
      check($sformatf("%s_count[%0d]", tag, i), 32'(fc_v[i]), 32'd0);
      check($sformatf("%s_sum[%0d]", tag, i), 32'(fs_v[i]), 32'd0);
      check($sformatf("%s_valid[%0d]", tag, i), 32'(sv_v[i]), 32'd0);
    end
  endtask

  task automatic checkpoint();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("locked[%0d]", i), 32'(locked_v[i]), 32'(exp_locked));
      check($sformatf("err_flags[%0d]", i),
            32'({ehp_v[i], ehs_v[i], evp_v[i], evs_v[i]}), 32'(exp_err));
      check($sformatf("frame_count[%0d]", i), 32'(fc_v[i]), 32'(exp_count));
    end
  endtask

  // kind: 0 clean, 1 long line, 2 short hsync, 3 3-line vsync,
  //       4 one line short, 5 reset mid-frame, 6 clean with clear pulse
  task automatic play_frame(input int kind, input int fl);
    int          nlines, vsw, len, hsw;
    bit          body_err, vbad, rep;
    logic [5:0]  p;
    logic [15:0] facc;
    nlines   = (kind == 4) ? VT - 1 : VT;
    vsw      = (kind == 3) ? VS + 1 : VS;
    body_err = (kind == 1) || (kind == 2) || (kind == 3);
    facc     = '0;
    for (int v = 0; v < nlines; v++) begin
      len = (kind == 1 && v == fl) ? HT + 1 : HT;
      hsw = (kind == 2 && v == fl) ? HS - 1 : HS;
      for (int h = 0; h < len; h++) begin
        p = '0;
        if (h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA) begin
          p = 6'($urandom_range(0, 63));
          facc = facc + 16'(p);
        end
        drive(h < hsw, v < vsw, p);
        clear = (kind == 6 && v == 5 && h == 0);
        if (clear) begin
          exp_count = '0;
          exp_err   = '0;
        end
        if (rst_left > 0) begin
          rst_left--;
          if (rst_left == 0) rst_n = 1'b1;
        end
        if (kind == 5 && v == 3 && h == 10) begin
          rst_n = 1'b0;
          rst_left = 3;
          #1;
          check_zero("midreset");
          exp_count  = '0;
          exp_err    = '0;
          exp_locked = 1'b0;
          armed      = 1'b0;
        end
        if (v == 1 && h == 5) checkpoint();
      end
    end
    vbad = (nlines != VT);
    if (armed && body_err) begin
      if (kind == 1) exp_err[3] = 1'b1;
      if (kind == 2) exp_err[2] = 1'b1;
      if (kind == 3) exp_err[0] = 1'b1;
    end
    if (armed && !body_err && vbad) exp_err[1] = 1'b1;
    rep = armed && !body_err && !vbad;
    if (rep) begin
      exp_count = exp_count + 16'd1;
      q0.push_back({facc, exp_count});
      q1.push_back({facc, exp_count});
    end
    exp_locked = rep;
    armed = !(armed && !body_err && vbad);
  endtask

  task automatic pop_check(input int i);
    logic [31:0] e;
    int n;
    n = (i == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_sum_valid[%0d] actual=1 required=0", i);
    end else begin
      if (i == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      check($sformatf("frame_sum[%0d]", i), 32'(fs_v[i]), 32'(e[31:16]));
      check($sformatf("sum_count[%0d]", i), 32'(fc_v[i]), 32'(e[15:0]));
    end
  endtask

  // Scoreboard monitor: every sum_valid pulse consumes one expected frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sv_v[0]) pop_check(0);
      if (sv_v[1]) pop_check(1);
    end
  end

  initial begin
    int kinds[17] = '{0, 0, 0, 1, 0, 6, 2, 0, 3, 0, 4, 0, 0, 6, 5, 0, 0};
    int rkinds[7] = '{0, 0, 1, 2, 3, 4, 6};
    rst_n      = 1'b0;
    clear      = 1'b0;
    vga_neg    = 8'h88;
    exp_count  = '0;
    exp_err    = '0;
    exp_locked = 1'b0;
    armed      = 1'b1;
    rst_left   = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (4) drive(1'b0, 1'b0, 6'd0);
    foreach (kinds[k]) play_frame(kinds[k], 5);
    for (int r = 0; r < 8; r++)
      play_frame(rkinds[$urandom_range(0, 6)], int'($urandom_range(2, VT - 2)));
    // Start one more frame so the last complete frame gets reported.
    repeat (8) drive(1'b1, 1'b1, 6'd0);
    repeat (2) @(negedge clk);
    check("pending_sums[0]", 32'(q0.size()), 32'd0);
    check("pending_sums[1]", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
